// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard scheduler.
//   FWD_*        : EX operand mux select encodings
//   mul_state_e  : multiply-occupancy FSM states
//   stage_t      : one shadow pipeline stage (EX/MEM/WB)
package hazard_pkg;

  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  // Shadow register indices are stored at this width; REG_AW must not exceed it.
  localparam int unsigned IDX_W = 8;
  // Multiply down-counter width, enough for MUL_LAT up to 8.
  localparam int unsigned CNT_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mul_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] rs_a;
    logic [IDX_W-1:0] rs_b;
    logic [IDX_W-1:0] rd;
    logic             regwrite;
    logic             memread;
    logic             is_mul;
  } stage_t;

endpackage

// File: rtl/fwd_select.sv
// fwd_select: operand forwarding comparator for one EX source register.
//   mem_*  : producer in MEM (EX/MEM register)
//   wb_*   : producer in WB  (MEM/WB register)
//   ex_rs  : source register of the instruction in EX
//   sel    : FWD_EX_MEM / FWD_MEM_WB / FWD_NONE
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned AW = 5
) (
  input  logic          mem_valid,
  input  logic          mem_regwrite,
  input  logic [AW-1:0] mem_rd,
  input  logic          wb_valid,
  input  logic          wb_regwrite,
  input  logic [AW-1:0] wb_rd,
  input  logic [AW-1:0] ex_rs,
  output logic [1:0]    sel
);

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = mem_valid && mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs);
    wb_hit  = wb_valid  && wb_regwrite  && (wb_rd  != '0) && (wb_rd  == ex_rs);
    sel     = FWD_NONE;
    // The younger producer (MEM) wins over the older one (WB).
    if (mem_hit)     sel = FWD_EX_MEM;
    else if (wb_hit) sel = FWD_MEM_WB;
  end

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stall / bubble / flush / forwarding control for the
// 5-stage integer core. Tracks in-flight destinations in a shadow EX/MEM/WB
// pipeline.
//   id_*             : decoded instruction currently in ID
//   ex_branch_taken  : branch in EX resolved taken
//   pc_write_en      : 0 holds the PC
//   if_id_write_en   : 0 holds IF/ID
//   if_id_flush      : clears IF/ID
//   id_ex_bubble     : loads a NOP into ID/EX
//   ex_hold          : holds ID/EX while a multiply is busy
//   forward_A/B      : EX operand mux selects
//   mul_busy         : multiply FSM in BUSY
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rsA,
  input  logic [REG_AW-1:0] id_rsB,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_is_mul,
  input  logic              ex_branch_taken,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              ex_hold,
  output logic [1:0]        forward_A,
  output logic [1:0]        forward_B,
  output logic              mul_busy
);

  localparam bit              MUL_MULTI    = (MUL_LAT > 1);
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = MUL_MULTI ? CNT_W'(MUL_LAT - 2) : '0;

  stage_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_stage;
  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       busy, luse, branch, mul_start, hold_ex;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  always_comb begin
    id_stage          = '0;
    id_stage.valid    = id_valid;
    id_stage.rs_a     = IDX_W'(id_rsA);
    id_stage.rs_b     = IDX_W'(id_rsB);
    id_stage.rd       = IDX_W'(id_rd);
    id_stage.regwrite = id_regwrite;
    id_stage.memread  = id_memread;
    id_stage.is_mul   = id_is_mul;
  end

  always_comb begin
    busy      = (state_q == ST_BUSY);
    luse      = id_valid && ex_q.valid && ex_q.memread && ex_q.regwrite &&
                (ex_q.rd != '0) &&
                ((ex_q.rd == id_stage.rs_a) || (ex_q.rd == id_stage.rs_b));
    // A branch can never legitimately overlap BUSY; ignore it there.
    branch    = ex_branch_taken && !busy;
    mul_start = !busy && ex_q.valid && ex_q.is_mul && MUL_MULTI;
    // The multiply stays in EX on the entry edge and every BUSY edge except
    // the last, giving MUL_LAT cycles of EX occupancy in total.
    hold_ex   = mul_start || (busy && (cnt_q != '0));
  end

  // Next-state for shadow stages and multiply FSM.
  always_comb begin
    ex_d    = id_stage;
    mem_d   = ex_q;
    wb_d    = mem_q;
    state_d = state_q;
    cnt_d   = cnt_q;

    if (hold_ex) begin
      ex_d  = ex_q;
      mem_d = '0;
    end else if (branch || luse) begin
      ex_d = '0;
    end

    if (mul_start) begin
      state_d = ST_BUSY;
      cnt_d   = MUL_CNT_INIT;
    end else if (busy) begin
      if (cnt_q == '0) state_d = ST_IDLE;
      else             cnt_d   = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  fwd_select #(.AW(IDX_W)) u_fwd_a (
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_rd       (mem_q.rd),
    .wb_valid     (wb_q.valid),
    .wb_regwrite  (wb_q.regwrite),
    .wb_rd        (wb_q.rd),
    .ex_rs        (ex_q.rs_a),
    .sel          (fwd_a_sel)
  );

  fwd_select #(.AW(IDX_W)) u_fwd_b (
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_rd       (mem_q.rd),
    .wb_valid     (wb_q.valid),
    .wb_regwrite  (wb_q.regwrite),
    .wb_rd        (wb_q.rd),
    .ex_rs        (ex_q.rs_b),
    .sel          (fwd_b_sel)
  );

  // Control outputs; priority rst > BUSY > branch > load-use.
  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    ex_hold        = 1'b0;
    mul_busy       = 1'b0;
    forward_A      = FWD_NONE;
    forward_B      = FWD_NONE;
    if (!rst) begin
      mul_busy  = busy;
      forward_A = fwd_a_sel;
      forward_B = fwd_b_sel;
      if (busy) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        ex_hold        = 1'b1;
      end else if (branch) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (luse) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_bubble   = 1'b1;
      end
    end
  end

  // WB only supplies a destination; its source/type fields are carried along.
  logic unused_wb_fields;
  assign unused_wb_fields = ^{wb_q.rs_a, wb_q.rs_b, wb_q.memread, wb_q.is_mul};

endmodule
